game_tick_sched: RTL and testbench

Programmable tick scheduler for the free-running 32-bit `clk_div` counter bus. It turns selected counter bits into single-cycle enable strobes for the game subsystems: player motion, barrels, sprite animation and sound. Each channel selects one tap bit and emits a one-cycle `tick` on every rising edge of that bit. A run/pause/step state machine gates all ticks, and a one-slot config handshake retunes channels without glitches.

---
 rtl/game_tick_sched_pkg.sv | 31 +++
 rtl/game_tick_sched_channel.sv | 63 ++++++
 rtl/game_tick_sched.sv | 117 +++++++++++
 tb/tb_game_tick_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_tick_sched_pkg.sv
// Shared encodings for the game tick scheduler: run states, commands and widths.
// The command-to-state rule lives here so the FSM reads as a single call.
package gtick_pkg;

  localparam int TAP_W = 5;
  localparam int CNT_W = 16;

  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_STEP  = 2'b11;

  localparam logic [1:0] CMD_STOP  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_STEP  = 2'b11;

  // PAUSE is meaningless from STOP, STEP is meaningless from RUN; both are ignored there.
  function automatic logic [1:0] cmd_next(input logic [1:0] st, input logic [1:0] cmd);
    logic [1:0] nxt;
    nxt = st;
    case (cmd)
      CMD_STOP:  nxt = ST_STOP;
      CMD_RUN:   nxt = ST_RUN;
      CMD_PAUSE: if (st == ST_RUN || st == ST_STEP) nxt = ST_PAUSE;
      default:   if (st == ST_STOP || st == ST_PAUSE) nxt = ST_STEP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/game_tick_sched_channel.sv
// One tick channel: taps a divider bit, detects its rising edge and emits a gated
// one-cycle strobe. A pending retune is taken on the channel's own edge when enabled.
module tick_channel
  import gtick_pkg::*;
#(
  parameter int DEF_TAP = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      clk_div_i,
  input  logic             gate_i,
  input  logic             pend_i,
  input  logic [TAP_W-1:0] new_tap_i,
  input  logic             new_en_i,
  output logic             applied_o,
  output logic             fire_o,
  output logic             tick_o
);

  logic [TAP_W-1:0] tap_q, tap_d;
  logic             en_q, en_d;
  logic             prev_q, prev_d;
  logic             tick_q, tick_d;
  logic             raw_edge;
  logic             apply;

  assign raw_edge = clk_div_i[tap_q] & ~prev_q;
  // An enabled channel only switches on its edge so the current period completes cleanly.
  assign apply    = pend_i & (~en_q | raw_edge);

  always_comb begin
    tap_d  = tap_q;
    en_d   = en_q;
    prev_d = clk_div_i[tap_q];
    // The switching edge is still judged with the old enable.
    tick_d = raw_edge & en_q & gate_i;
    if (apply) begin
      tap_d  = new_tap_i;
      en_d   = new_en_i;
      // Seeding prev from the new tap keeps the retune from looking like an edge.
      prev_d = clk_div_i[new_tap_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap_q  <= TAP_W'(DEF_TAP);
      en_q   <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tap_q  <= tap_d;
      en_q   <= en_d;
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign applied_o = apply;
  assign fire_o    = tick_d;
  assign tick_o    = tick_q;

endmodule

// File: rtl/game_tick_sched.sv
// Tick scheduler top: run/pause/step FSM, one-slot config handshake and the
// channel-0 tick counter around NCH tick_channel instances.
module game_tick_sched
  import gtick_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DEF_TAP = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      clk_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic             cfg_en,
  input  logic             ctrl_valid,
  input  logic [1:0]       ctrl_cmd,
  output logic [NCH-1:0]   tick,
  output logic [1:0]       run_state,
  output logic [CNT_W-1:0] tick_count
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_ch_q, pend_ch_d;
  logic [TAP_W-1:0] pend_tap_q, pend_tap_d;
  logic             pend_en_q, pend_en_d;
  logic [NCH-1:0]   pend_sel;
  logic [NCH-1:0]   applied;
  logic [NCH-1:0]   fire;
  logic             gate;
  logic             ch_valid;
  logic             accept;

  assign gate      = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign ch_valid  = int'(pend_ch_q) < NCH;
  assign accept    = cfg_valid && !pend_vld_q;
  assign cfg_ready = !pend_vld_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign pend_sel[i] = pend_vld_q && (int'(pend_ch_q) == i);

    tick_channel #(
      .DEF_TAP (DEF_TAP)
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (rst),
      .clk_div_i (clk_div),
      .gate_i    (gate),
      .pend_i    (pend_sel[i]),
      .new_tap_i (pend_tap_q),
      .new_en_i  (pend_en_q),
      .applied_o (applied[i]),
      .fire_o    (fire[i]),
      .tick_o    (tick[i])
    );
  end

  // Out-of-range targets are accepted and dropped so the writer never stalls.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_ch_d  = pend_ch_q;
    pend_tap_d = pend_tap_q;
    pend_en_d  = pend_en_q;
    if (accept) begin
      pend_vld_d = 1'b1;
      pend_ch_d  = cfg_ch;
      pend_tap_d = cfg_tap;
      pend_en_d  = cfg_en;
    end else if (pend_vld_q && (!ch_valid || (|applied))) begin
      pend_vld_d = 1'b0;
    end
  end

  // A command in the edge cycle takes priority over the automatic STEP exit.
  always_comb begin
    state_d = state_q;
    if (ctrl_valid) begin
      state_d = cmd_next(state_q, ctrl_cmd);
    end else if (state_q == ST_STEP && fire[0]) begin
      state_d = ST_PAUSE;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_valid && ctrl_cmd == CMD_STOP) begin
      cnt_d = '0;
    end else if (fire[0]) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_ch_q  <= '0;
      pend_tap_q <= '0;
      pend_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_ch_q  <= pend_ch_d;
      pend_tap_q <= pend_tap_d;
      pend_en_q  <= pend_en_d;
    end
  end

  assign run_state  = state_q;
  assign tick_count = cnt_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched: a tick model driven from the bench's own
// divider counter predicts every strobe and the channel-0 count cycle by cycle.
module tb_game_tick_sched;
  import gtick_pkg::*;

  localparam int NCH = 4;

  logic             clk;
  logic             rst;
  logic [31:0]      clk_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [TAP_W-1:0] cfg_tap;
  logic             cfg_en;
  logic             ctrl_valid;
  logic [1:0]       ctrl_cmd;
  logic [NCH-1:0]   tick;
  logic [1:0]       run_state;
  logic [CNT_W-1:0] tick_count;

  logic             cfg_valid2;
  logic             cfg_ready2;
  logic [1:0]       cfg_ch2;
  logic [TAP_W-1:0] cfg_tap2;
  logic             cfg_en2;
  logic             ctrl_valid2;
  logic [1:0]       ctrl_cmd2;
  logic [1:0]       tick2;
  logic [1:0]       run_state2;
  logic [CNT_W-1:0] tick_count2;

  int checks;
  int failures;

  bit               mgate;
  bit               men [NCH];
  int               mtap [NCH];
  logic [CNT_W-1:0] mcnt;

  game_tick_sched #(.NCH(NCH), .DEF_TAP(20)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_tap    (cfg_tap),
    .cfg_en     (cfg_en),
    .ctrl_valid (ctrl_valid),
    .ctrl_cmd   (ctrl_cmd),
    .tick       (tick),
    .run_state  (run_state),
    .tick_count (tick_count)
  );

  // Narrow instance so an out-of-range channel index is expressible on cfg_ch.
  game_tick_sched #(.NCH(2), .DEF_TAP(20)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .cfg_valid  (cfg_valid2),
    .cfg_ready  (cfg_ready2),
    .cfg_ch     (cfg_ch2),
    .cfg_tap    (cfg_tap2),
    .cfg_en     (cfg_en2),
    .ctrl_valid (ctrl_valid2),
    .ctrl_cmd   (ctrl_cmd2),
    .tick       (tick2),
    .run_state  (run_state2),
    .tick_count (tick_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clk_div = clk_div + 32'd1;
  endtask

  // Edge at tap k is seen when the sampled count is 2^k modulo 2^(k+1).
  task automatic cyc_chk(input string tag, input bit clr = 1'b0);
    logic [NCH-1:0] e;
    for (int i = 0; i < NCH; i++) begin
      e[i] = mgate && men[i] &&
             ((clk_div & ((32'd2 << mtap[i]) - 32'd1)) == (32'd1 << mtap[i]));
    end
    cyc();
    if (clr) mcnt = '0;
    else if (e[0]) mcnt = mcnt + 1'b1;
    chk({tag, "_tick"}, 32'(tick), 32'(e));
    chk({tag, "_cnt"}, 32'(tick_count), 32'(mcnt));
  endtask

  task automatic cmd(input logic [1:0] c, input bit gate_after);
    ctrl_valid = 1'b1;
    ctrl_cmd   = c;
    cyc_chk("cmd", c == CMD_STOP);
    ctrl_valid = 1'b0;
    mgate      = gate_after;
  endtask

  // Config write to a currently disabled channel: busy one cycle, then applied.
  task automatic cfg_dis(input int ch, input int tap, input bit en);
    cfg_valid = 1'b1;
    cfg_ch    = ch[1:0];
    cfg_tap   = tap[TAP_W-1:0];
    cfg_en    = en;
    cyc_chk("cfg_acc");
    cfg_valid = 1'b0;
    chk("cfg_busy", 32'(cfg_ready), 32'd0);
    cyc_chk("cfg_apl");
    chk("cfg_free", 32'(cfg_ready), 32'd1);
    men[ch]  = en;
    mtap[ch] = tap;
  endtask

  task automatic wait_phase(input logic [31:0] m, input logic [31:0] v);
    int n;
    n = 0;
    while (((clk_div & m) != v) && n < 64) begin
      cyc_chk("wait");
      n++;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; clk_div = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_tap = '0; cfg_en = 1'b0;
    ctrl_valid = 1'b0; ctrl_cmd = '0;
    cfg_valid2 = 1'b0; cfg_ch2 = '0; cfg_tap2 = '0; cfg_en2 = 1'b0;
    ctrl_valid2 = 1'b0; ctrl_cmd2 = '0;
    mgate = 1'b0; mcnt = '0;
    for (int i = 0; i < NCH; i++) begin men[i] = 1'b0; mtap[i] = 20; end

    // Reset values
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_state", 32'(run_state), 32'(ST_STOP));
    chk("rst_cnt", 32'(tick_count), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    repeat (3) cyc();
    rst = 1'b0;

    // Basic period: ch0 at tap 3 pulses every 16 cycles under RUN
    cfg_dis(0, 3, 1'b1);
    cyc_chk("stopped");
    cmd(CMD_RUN, 1'b1);
    chk("run_state", 32'(run_state), 32'(ST_RUN));
    repeat (48) cyc_chk("run");

    // Pause holds ticks and count
    cmd(CMD_PAUSE, 1'b0);
    chk("pause_state", 32'(run_state), 32'(ST_PAUSE));
    repeat (200) cyc_chk("pause");

    // Step yields exactly one ch0 tick then returns to PAUSE
    cmd(CMD_STEP, 1'b1);
    chk("step_state", 32'(run_state), 32'(ST_STEP));
    for (int i = 0; i < 40; i++) begin
      bit f;
      f = ((clk_div & 32'd15) == 32'd8);
      cyc_chk("step");
      if (f) begin
        mgate = 1'b0;
        break;
      end
    end
    chk("step_exit", 32'(run_state), 32'(ST_PAUSE));
    repeat (40) cyc_chk("after_step");

    // Retune ch1 from tap 4 to tap 2 mid-period
    cfg_dis(1, 4, 1'b1);
    cmd(CMD_RUN, 1'b1);
    repeat (40) cyc_chk("ch1_t4");
    wait_phase(32'd31, 32'd20);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_tap = 5'd2; cfg_en = 1'b1;
    cyc_chk("rt_acc");
    cfg_valid = 1'b0;
    chk("rt_busy0", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 27; i++) begin
      if (i == 5) begin
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_tap = 5'd1; cfg_en = 1'b1;
      end
      cyc_chk("rt_wait");
      cfg_valid = 1'b0;
      chk("rt_busy", 32'(cfg_ready), 32'd0);
    end
    cyc_chk("rt_apply");
    chk("rt_ready", 32'(cfg_ready), 32'd1);
    mtap[1] = 2;
    repeat (40) cyc_chk("rt_new");

    // Out-of-range channel is discarded on the two-channel instance
    chk("d2_ready0", 32'(cfg_ready2), 32'd1);
    cfg_valid2 = 1'b1; cfg_ch2 = 2'd3; cfg_tap2 = 5'd1; cfg_en2 = 1'b1;
    cyc_chk("d2_acc");
    cfg_valid2 = 1'b0;
    chk("d2_busy", 32'(cfg_ready2), 32'd0);
    cyc_chk("d2_drop");
    chk("d2_ready1", 32'(cfg_ready2), 32'd1);
    repeat (8) cyc_chk("d2_idle");
    chk("d2_tick", 32'(tick2), 32'd0);
    chk("d2_state", 32'(run_state2), 32'(ST_STOP));
    chk("d2_cnt", 32'(tick_count2), 32'd0);

    // STOP coinciding with a ch0 edge: tick still emitted, count cleared
    wait_phase(32'd15, 32'd8);
    cmd(CMD_STOP, 1'b0);
    chk("stop_state", 32'(run_state), 32'(ST_STOP));
    chk("stop_cnt", 32'(tick_count), 32'd0);
    repeat (20) cyc_chk("stopped2");
    cmd(CMD_RUN, 1'b1);
    repeat (40) cyc_chk("rerun");

    // Async reset mid-run with a pending ch1 retune and tick[0] high
    wait_phase(32'd15, 32'd5);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_tap = 5'd6; cfg_en = 1'b1;
    cyc_chk("pend_acc");
    cfg_valid = 1'b0;
    repeat (3) cyc_chk("pend_hold");
    chk("pend_busy", 32'(cfg_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_state", 32'(run_state), 32'(ST_STOP));
    chk("arst_cnt", 32'(tick_count), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    cyc();
    rst = 1'b0;
    mgate = 1'b0; mcnt = '0;
    for (int i = 0; i < NCH; i++) begin men[i] = 1'b0; mtap[i] = 20; end
    cmd(CMD_RUN, 1'b1);
    repeat (40) cyc_chk("post_rst");
    chk("post_ready", 32'(cfg_ready), 32'd1);
    cfg_dis(0, 3, 1'b1);
    repeat (40) cyc_chk("reen");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
